alu_result_writeback: RTL and testbench

// - Write-side counterpart of the ALU datapath: takes the ALU result and carry/overflow,

---
 rtl/alu_result_writeback_pkg.sv | 37 +++
 rtl/alu_result_writeback_flag.sv | 23 ++
 rtl/alu_result_writeback.sv | 109 ++++++++++
 tb/tb_alu_result_writeback.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_writeback_pkg.sv
// Shared codes for the ALU writeback path: destination encodings (aligned with the
// ALU input-mux select codes), status-register bit positions, FSM states and reset defaults.
package alu_result_writeback_pkg;

    localparam logic [2:0] WB_DEST_A     = 3'd0;
    localparam logic [2:0] WB_DEST_X     = 3'd1;
    localparam logic [2:0] WB_DEST_Y     = 3'd2;
    localparam logic [2:0] WB_DEST_DATA  = 3'd3;
    localparam logic [2:0] WB_DEST_SP    = 3'd4;
    localparam logic [2:0] WB_DEST_FLAGS = 3'd5;
    localparam logic [2:0] WB_DEST_P     = 3'd6;
    localparam logic [2:0] WB_DEST_NOP   = 3'd7;

    localparam int P_BIT_C = 0;
    localparam int P_BIT_Z = 1;
    localparam int P_BIT_I = 2;
    localparam int P_BIT_D = 3;
    localparam int P_BIT_B = 4;
    localparam int P_BIT_U = 5;
    localparam int P_BIT_V = 6;
    localparam int P_BIT_N = 7;

    // flag_mask bit order is {N,V,Z,C}
    localparam int MASK_C = 0;
    localparam int MASK_Z = 1;
    localparam int MASK_V = 2;
    localparam int MASK_N = 3;

    localparam logic [7:0] P_RESET_DEF  = 8'h24;
    localparam logic [7:0] SP_RESET_DEF = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MEM_WR = 1'b1
    } wb_state_e;

endpackage

// File: rtl/alu_result_writeback_flag.sv
// Combinational status-flag merge: applies N/V/Z/C from the ALU result under the mask.
// Unmasked bits pass through; bit5 always reads 1.
module alu_flag_unit
    import alu_result_writeback_pkg::*;
(
    input  logic [7:0] i_result,
    input  logic       i_cout,
    input  logic       i_vout,
    input  logic [3:0] i_mask,
    input  logic [7:0] i_p,
    output logic [7:0] o_p
);

    always_comb begin
        o_p = i_p;
        if (i_mask[MASK_N]) o_p[P_BIT_N] = i_result[7];
        if (i_mask[MASK_V]) o_p[P_BIT_V] = i_vout;
        if (i_mask[MASK_Z]) o_p[P_BIT_Z] = (i_result == 8'h00);
        if (i_mask[MASK_C]) o_p[P_BIT_C] = i_cout;
        o_p[P_BIT_U] = 1'b1;
    end

endmodule

// File: rtl/alu_result_writeback.sv
// ALU result writeback: owns A/X/Y/SP/P, 1-cycle register writes, full throughput.
// Memory writes hold mem_wr/mem_data_out until mem_ack; wb_ready drops meanwhile.
module alu_result_writeback
    import alu_result_writeback_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_RESET_DEF,
    parameter logic [7:0] P_RESET  = P_RESET_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wb_valid,
    output logic       o_wb_ready,
    input  logic [2:0] i_wb_dest,
    input  logic [7:0] i_wb_result,
    input  logic       i_wb_cout,
    input  logic       i_wb_vout,
    input  logic [3:0] i_flag_mask,
    output logic       o_mem_wr,
    output logic [7:0] o_mem_data_out,
    input  logic       i_mem_ack,
    output logic [7:0] o_a_reg,
    output logic [7:0] o_x_reg,
    output logic [7:0] o_y_reg,
    output logic [7:0] o_sp,
    output logic [7:0] o_p_reg
);

    wb_state_e  r_state;
    wb_state_e  w_state_nxt;
    logic [7:0] r_a, r_x, r_y, r_sp, r_p, r_mem_data;
    logic       w_accept;
    logic       w_flag_en;
    logic [7:0] w_p_flags;
    logic [7:0] w_p_plp;

    always_comb begin
        w_state_nxt = r_state;
        o_wb_ready  = 1'b0;
        o_mem_wr    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_wb_ready = 1'b1;
                w_accept   = i_wb_valid;
                if (i_wb_valid && (i_wb_dest == WB_DEST_DATA))
                    w_state_nxt = ST_MEM_WR;
            end
            ST_MEM_WR: begin
                o_mem_wr = 1'b1;
                if (i_mem_ack)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_flag_en = w_accept && (i_wb_dest != WB_DEST_P) && (i_wb_dest != WB_DEST_NOP);

    // PLP-style load: B reads back 0 and the unused bit stays 1
    always_comb begin
        w_p_plp          = i_wb_result;
        w_p_plp[P_BIT_U] = 1'b1;
        w_p_plp[P_BIT_B] = 1'b0;
    end

    alu_flag_unit u_flag (
        .i_result (i_wb_result),
        .i_cout   (i_wb_cout),
        .i_vout   (i_wb_vout),
        .i_mask   (i_flag_mask),
        .i_p      (r_p),
        .o_p      (w_p_flags)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_a        <= 8'h00;
            r_x        <= 8'h00;
            r_y        <= 8'h00;
            r_sp       <= SP_RESET;
            r_p        <= P_RESET;
            r_mem_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                case (i_wb_dest)
                    WB_DEST_A:    r_a        <= i_wb_result;
                    WB_DEST_X:    r_x        <= i_wb_result;
                    WB_DEST_Y:    r_y        <= i_wb_result;
                    WB_DEST_DATA: r_mem_data <= i_wb_result;
                    WB_DEST_SP:   r_sp       <= i_wb_result;
                    WB_DEST_P:    r_p        <= w_p_plp;
                    default: ;
                endcase
            end
            if (w_flag_en)
                r_p <= w_p_flags;
        end
    end

    assign o_mem_data_out = r_mem_data;
    assign o_a_reg        = r_a;
    assign o_x_reg        = r_x;
    assign o_y_reg        = r_y;
    assign o_sp           = r_sp;
    assign o_p_reg        = r_p;

endmodule

// File: tb/tb_alu_result_writeback.sv
// Scoreboarded bench for alu_result_writeback: register snapshots and memory data are
// queued at accept and compared when the DUT presents them.
module tb_alu_result_writeback;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] sp;
        logic [7:0] p;
    } regs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wb_valid = 1'b0;
    logic       wb_ready;
    logic [2:0] wb_dest = 3'd7;
    logic [7:0] wb_result = 8'h00;
    logic       wb_cout = 1'b0;
    logic       wb_vout = 1'b0;
    logic [3:0] flag_mask = 4'h0;
    logic       mem_wr;
    logic [7:0] mem_data_out;
    logic       mem_ack = 1'b0;
    logic [7:0] a_reg, x_reg, y_reg, sp, p_reg;

    int n_tests = 0;
    int n_fail  = 0;

    regs_t      model;
    regs_t      reg_q[$];
    logic [7:0] mem_q[$];

    always #5 clk = ~clk;

    alu_result_writeback dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wb_valid     (wb_valid),
        .o_wb_ready     (wb_ready),
        .i_wb_dest      (wb_dest),
        .i_wb_result    (wb_result),
        .i_wb_cout      (wb_cout),
        .i_wb_vout      (wb_vout),
        .i_flag_mask    (flag_mask),
        .o_mem_wr       (mem_wr),
        .o_mem_data_out (mem_data_out),
        .i_mem_ack      (mem_ack),
        .o_a_reg        (a_reg),
        .o_x_reg        (x_reg),
        .o_y_reg        (y_reg),
        .o_sp           (sp),
        .o_p_reg        (p_reg)
    );

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic regs_t reset_regs();
        regs_t r;
        r.a = 8'h00; r.x = 8'h00; r.y = 8'h00; r.sp = 8'hFF; r.p = 8'h24;
        return r;
    endfunction

    // Reference behaviour of one accepted request on the architectural registers
    function automatic regs_t apply(input regs_t r, input logic [2:0] d, input logic [7:0] res,
                                    input logic c, input logic v, input logic [3:0] m);
        regs_t n = r;
        case (d)
            3'd0: n.a  = res;
            3'd1: n.x  = res;
            3'd2: n.y  = res;
            3'd4: n.sp = res;
            default: ;
        endcase
        if (d == 3'd6) begin
            n.p = {res[7:6], 2'b10, res[3:0]};
        end else if (d != 3'd7) begin
            if (m[3]) n.p[7] = res[7];
            if (m[2]) n.p[6] = v;
            if (m[1]) n.p[1] = (res == 8'h00);
            if (m[0]) n.p[0] = c;
        end
        return n;
    endfunction

    function automatic regs_t dut_regs();
        regs_t r;
        r.a = a_reg; r.x = x_reg; r.y = y_reg; r.sp = sp; r.p = p_reg;
        return r;
    endfunction

    task automatic compare_regs(input string tag);
        regs_t e;
        if (reg_q.size() == 0) begin
            check({tag, "_sb_empty"}, 40'd0, 40'd1);
        end else begin
            e = reg_q.pop_front();
            check(tag, dut_regs(), e);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, then score the register file.
    task automatic do_wb(input string tag, input logic [2:0] d, input logic [7:0] res,
                         input logic c, input logic v, input logic [3:0] m);
        int waited = 0;
        wb_valid = 1'b1; wb_dest = d; wb_result = res;
        wb_cout = c; wb_vout = v; flag_mask = m;
        while (!wb_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!wb_ready) begin
            check({tag, "_ready_timeout"}, 40'd0, 40'd1);
            wb_valid = 1'b0;
        end else begin
            model = apply(model, d, res, c, v, m);
            reg_q.push_back(model);
            if (d == 3'd3) mem_q.push_back(res);
            tick();
            wb_valid = 1'b0;
            compare_regs(tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model = reset_regs();
    endtask

    initial begin
        logic [7:0] exp_d;

        // Reset state
        do_reset();
        reg_q.push_back(model);
        compare_regs("reset_regs");
        check("reset_ctrl", {38'd0, mem_wr, wb_ready}, {38'd0, 1'b0, 1'b1});
        check("reset_mdata", {32'd0, mem_data_out}, 40'd0);

        // A <= 00 with all flags enabled
        do_wb("wr_a_zero", 3'd0, 8'h00, 1'b1, 1'b0, 4'b1111);
        check("p_after_a", {32'd0, p_reg}, {32'd0, 8'h27});

        // Back-to-back X then Y, N/Z only
        do_wb("wr_x_80", 3'd1, 8'h80, 1'b0, 1'b1, 4'b1010);
        do_wb("wr_y_7f", 3'd2, 8'h7F, 1'b0, 1'b1, 4'b1010);
        check("p_after_xy", {32'd0, p_reg}, {32'd0, 8'h25});

        // SP write plus flags-only request
        do_wb("wr_sp", 3'd4, 8'h3C, 1'b0, 1'b0, 4'b0000);
        do_wb("flags_only", 3'd5, 8'hC0, 1'b0, 1'b1, 4'b1111);

        // Memory write with ack after three wait cycles; a request arrives meanwhile
        do_wb("wr_mem", 3'd3, 8'hA5, 1'b1, 1'b0, 4'b0001);
        if (mem_q.size() == 0) begin
            check("mem_sb_empty", 40'd0, 40'd1);
        end else begin
            exp_d = mem_q.pop_front();
            check("mem_data", {32'd0, mem_data_out}, {32'd0, exp_d});
            check("mem_wr_set", {39'd0, mem_wr}, 40'd1);
            wb_valid = 1'b1; wb_dest = 3'd0; wb_result = 8'h33; flag_mask = 4'b1111;
            for (int i = 0; i < 3; i++) begin
                check("mem_hold", {30'd0, mem_wr, wb_ready, mem_data_out}, {30'd0, 1'b1, 1'b0, exp_d});
                tick();
            end
            wb_valid = 1'b0;
            reg_q.push_back(model);
            compare_regs("no_accept_in_memwr");
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            check("mem_ack_release", {38'd0, mem_wr, wb_ready}, {38'd0, 1'b0, 1'b1});
        end
        // Ack in IDLE is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ack_idle", {38'd0, mem_wr, wb_ready}, {38'd0, 1'b0, 1'b1});

        // PLP load, then a no-op
        do_wb("plp_ff", 3'd6, 8'hFF, 1'b0, 1'b0, 4'b1111);
        check("plp_value", {32'd0, p_reg}, {32'd0, 8'hEF});
        do_wb("plp_00", 3'd6, 8'h00, 1'b1, 1'b1, 4'b1111);
        do_wb("nop", 3'd7, 8'h00, 1'b1, 1'b1, 4'b1111);

        // Random register/flag traffic
        for (int i = 0; i < 40; i++) begin
            logic [2:0] d;
            d = 3'($urandom_range(0, 7));
            if (d == 3'd3) d = 3'd5;
            do_wb("rand", d, 8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        // Reset in the middle of a pending memory write, with ack asserted alongside
        do_wb("wr_mem2", 3'd3, 8'h5A, 1'b0, 1'b0, 4'b0000);
        if (mem_q.size() != 0) begin
            exp_d = mem_q.pop_front();
            check("mem2_data", {31'd0, mem_wr, mem_data_out}, {31'd0, 1'b1, exp_d});
        end
        tick();
        rst = 1'b1;
        mem_ack = 1'b1;
        tick();
        rst = 1'b0;
        mem_ack = 1'b0;
        model = reset_regs();
        check("rst_memwr_ctrl", {38'd0, mem_wr, wb_ready}, {38'd0, 1'b0, 1'b1});
        check("rst_memwr_mdata", {32'd0, mem_data_out}, 40'd0);
        reg_q.push_back(model);
        compare_regs("rst_memwr_regs");
        tick();
        check("rst_memwr_stays", {38'd0, mem_wr, wb_ready}, {38'd0, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
